cpu_memory: RTL and testbench
=============================

# cpu_memory

Memory-access stage of the mox125 pipeline, directly downstream of `cpu_execute` and upstream of write-back. It takes the execute stage's registered results (control bits, address, store data, register results and indices) and performs at most one big-endian load or store per instruction over a Wishbone-classic master port. It stalls the upstream stages while a bus cycle is outstanding. It forwards register results and write enables to write-back.

## Interface
Parameters:
- `PCB_WIDTH`, 5: width of pipeline control bits (from `defines.h`).

Ports:
- `clk_i`  in  1  clock; the single clock for the block.
- `rst_i`  in  1  reset; synchronous, active-high.
- `pipeline_control_bits_i`  in  `PCB_WIDTH`  control bits from execute. Bit `PCB_WA` is the reg0 write enable, `PCB_WB` the reg1 write enable, `PCB_RM` memory read, `PCB_WM` memory write.
- `mem_size_i`  in  2  access size: 00 byte, 01 short, 10 long; 11 is treated as long.
- `memory_address_i`  in  32  byte address.
- `mem_result_i`  in  32  store data, right-justified.
- `reg0_result_i`, `reg1_result_i`  in  32  ALU results.
- `register0_write_index_i`, `register1_write_index_i`  in  4  destination indices.
- `PC_i`  in  32  instruction PC, passed through.
- `stall_o`  out  1  upstream must hold its outputs while this is high.
- `pipeline_control_bits_o`  out  `PCB_WIDTH`  control bits to write-back.
- `register_wea_o`, `register_web_o`  out  1  write enables to write-back.
- `reg0_result_o`, `reg1_result_o`  out  32  values to write back.
- `register0_write_index_o`, `register1_write_index_o`  out  4  write indices.
- `PC_o`  out  32  PC passed through.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master strobes.
- `wb_adr_o`  out  32  word address; bits [1:0] are forced to 0.
- `wb_sel_o`  out  4  byte lane selects; bit 3 is the lane for dat[31:24].
- `wb_dat_o`  out  32  store data, lane-replicated.
- `wb_dat_i`  in  32  load data.
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE, input carries neither `PCB_RM` nor `PCB_WM`:
  - Pass all inputs to the outputs registered, one cycle.
  - `register_wea_o`/`register_web_o` take `PCB_WA`/`PCB_WB`.
- IDLE, input carries `PCB_RM` or `PCB_WM`:
  - Capture all inputs into holding registers.
  - Drive `wb_cyc_o`=`wb_stb_o`=1, `wb_we_o`=`PCB_WM`. `PCB_WM` has priority if both bits are set.
  - Go to ACCESS. In the same edge, drive `pipeline_control_bits_o`/enables to 0 (bubble).
- ACCESS:
  - Hold the bus signals stable until `wb_ack_i`.
  - On ack: drop `cyc`/`stb`/`we`, emit the captured instruction to the outputs with its enables, and return to IDLE.
  - For a load, `reg0_result_o` is the extracted load data.
  - For a store, `reg0_result_o` is `reg0_result_i` (push/jsr $sp update).
  - `reg1_result_o` always passes through (pop pointer update).
- Lane mapping (big-endian, a = address[1:0]):
  - Byte: `sel` = 4'b1000 >> a. Data lane is dat[31-8a : 24-8a]. Store data is `{4{mem_result_i[7:0]}}`.
  - Short: `sel` = a[1] ? 4'b0011 : 4'b1100. Data is the upper or lower half. Store data is `{2{mem_result_i[15:0]}}`. a[0] is ignored.
  - Long: `sel` = 4'b1111. a is ignored.
  - Loads zero-extend to 32 bits.
- `stall_o` = (state == ACCESS). It is combinational from the state register only.
- Inputs are ignored while in ACCESS. Upstream holds them, and they are re-evaluated in IDLE; this is legal because the instruction was already captured.

## Timing
- Reset (synchronous): state IDLE; `wb_cyc_o`/`stb`/`we` = 0; `wb_sel_o`, `wb_adr_o`, `wb_dat_o` = 0; `pipeline_control_bits_o` = 0; enables = 0; results, indices and `PC_o` = 0; `stall_o` = 0.
- Reset in ACCESS aborts the cycle: `cyc`/`stb` drop on that edge and no result is emitted.
- Non-memory latency: 1 cycle, throughput 1 per cycle.
- Memory op accepted at edge N: `stb` is high from N. Ack sampled at edge N+k (k≥1) gives the result valid after N+k and `stall_o` low after N+k. The minimum occupancy is 2 cycles per memory op.
- The instruction on the input at the ack edge is not consumed. It is taken at the next IDLE edge.
- `wb_ack_i` while in IDLE is ignored.

## Structure
- Add `PCB_RM` and `PCB_WM` bit positions and the `MEM_SIZE_*` encodings to `defines.h`, next to `PCB_WA`/`PCB_WB`.
- One sub-module, `cpu_memory_lanes`: combinational `sel`, store-data replication, and load extraction/zero-extension from size and a.

## Test plan
- ALU pass-through: WA=1, idx=3, reg0=0x12345678, no mem bits → one cycle later `register_wea_o`=1, `reg0_result_o`=0x12345678, `wb_cyc_o`=0, `stall_o`=0.
- Byte load at 0x1003, slave returns 0xAABBCCDD after 3 cycles → `wb_sel_o`=0001, `wb_adr_o`=0x1000, `stall_o` high 3 cycles, `reg0_result_o`=0x000000DD.
- Short store of 0x0000BEEF at 0x2002 → `wb_we_o`=1, `sel`=0011, `dat_o`=0xBEEFBEEF; write-back sees `reg0_result_i` unchanged.
- Pop (load long at 0x3000 with reg1=0x3004, WA=WB=1), immediate ack → `reg0_result_o`=`wb_dat_i`, `reg1_result_o`=0x3004, both enables set in the same cycle.
- Back-to-back load, then ALU op held upstream → ALU result emitted exactly one cycle after the load result, with no duplication.
- `rst_i` asserted during ACCESS with no ack → next cycle `cyc`/`stb`=0, state IDLE, no write enables asserted.

Source files
------------

// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the mox125 memory-access stage: control-bit
// positions, access-size encodings and the stage FSM states.
package cpu_memory_pkg;

  localparam int PCB_W  = 5;
  localparam int PCB_WA = 0;
  localparam int PCB_WB = 1;
  localparam int PCB_RM = 2;
  localparam int PCB_WM = 3;

  localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] MEM_SIZE_SHORT = 2'b01;
  localparam logic [1:0] MEM_SIZE_LONG  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } mem_state_e;

endpackage

// File: rtl/cpu_memory_lanes.sv
// Big-endian lane steering: byte selects, store-data replication and
// load-data extraction with zero extension.
module cpu_memory_lanes
  import cpu_memory_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_st_data,
  output logic [31:0] o_ld_data
);

  always_comb begin
    o_sel     = 4'b1111;
    o_st_data = i_st_data;
    o_ld_data = i_ld_data;
    case (i_size)
      MEM_SIZE_BYTE: begin
        o_sel     = 4'b1000 >> i_a;
        o_st_data = {4{i_st_data[7:0]}};
        case (i_a)
          2'd0:    o_ld_data = {24'd0, i_ld_data[31:24]};
          2'd1:    o_ld_data = {24'd0, i_ld_data[23:16]};
          2'd2:    o_ld_data = {24'd0, i_ld_data[15:8]};
          default: o_ld_data = {24'd0, i_ld_data[7:0]};
        endcase
      end
      MEM_SIZE_SHORT: begin
        o_sel     = i_a[1] ? 4'b0011 : 4'b1100;
        o_st_data = {2{i_st_data[15:0]}};
        o_ld_data = i_a[1] ? {16'd0, i_ld_data[15:0]} : {16'd0, i_ld_data[31:16]};
      end
      default: ;  // long, and the 2'b11 encoding which behaves as long
    endcase
  end

endmodule

// File: rtl/cpu_memory.sv
// Memory-access stage: one Wishbone-classic load/store per instruction,
// stalling upstream while the bus cycle is outstanding.
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int PCB_WIDTH = PCB_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [1:0]           mem_size_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          PC_i,
  output logic                 stall_o,
  output logic [PCB_WIDTH-1:0] pipeline_control_bits_o,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [31:0]          reg0_result_o,
  output logic [31:0]          reg1_result_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic [31:0]          PC_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i
);

  mem_state_e           r_state;
  logic [PCB_WIDTH-1:0] r_h_pcb;
  logic [1:0]           r_h_size;
  logic [1:0]           r_h_a;
  logic                 r_h_load;
  logic [31:0]          r_h_reg0;
  logic [31:0]          r_h_reg1;
  logic [31:0]          r_h_pc;
  logic [3:0]           r_h_idx0;
  logic [3:0]           r_h_idx1;

  logic                 w_mem_req;
  logic [1:0]           w_size;
  logic [1:0]           w_a;
  logic [3:0]           w_sel;
  logic [31:0]          w_st_data;
  logic [31:0]          w_ld_data;

  assign w_mem_req = pipeline_control_bits_i[PCB_RM] | pipeline_control_bits_i[PCB_WM];
  assign stall_o   = (r_state == ST_ACCESS);

  // Lanes see the live request in IDLE and the captured size/offset in ACCESS.
  assign w_size = (r_state == ST_IDLE) ? mem_size_i : r_h_size;
  assign w_a    = (r_state == ST_IDLE) ? memory_address_i[1:0] : r_h_a;

  cpu_memory_lanes u_lanes (
    .i_size    (w_size),
    .i_a       (w_a),
    .i_st_data (mem_result_i),
    .i_ld_data (wb_dat_i),
    .o_sel     (w_sel),
    .o_st_data (w_st_data),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && w_mem_req) begin
      r_h_pcb  <= pipeline_control_bits_i;
      r_h_size <= mem_size_i;
      r_h_a    <= memory_address_i[1:0];
      r_h_load <= pipeline_control_bits_i[PCB_RM] & ~pipeline_control_bits_i[PCB_WM];
      r_h_reg0 <= reg0_result_i;
      r_h_reg1 <= reg1_result_i;
      r_h_pc   <= PC_i;
      r_h_idx0 <= register0_write_index_i;
      r_h_idx1 <= register1_write_index_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state                 <= ST_IDLE;
      wb_cyc_o                <= 1'b0;
      wb_stb_o                <= 1'b0;
      wb_we_o                 <= 1'b0;
      wb_adr_o                <= '0;
      wb_sel_o                <= '0;
      wb_dat_o                <= '0;
      pipeline_control_bits_o <= '0;
      register_wea_o          <= 1'b0;
      register_web_o          <= 1'b0;
      reg0_result_o           <= '0;
      reg1_result_o           <= '0;
      register0_write_index_o <= '0;
      register1_write_index_o <= '0;
      PC_o                    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_mem_req) begin
        r_state                 <= ST_ACCESS;
        wb_cyc_o                <= 1'b1;
        wb_stb_o                <= 1'b1;
        wb_we_o                 <= pipeline_control_bits_i[PCB_WM];
        wb_adr_o                <= {memory_address_i[31:2], 2'b00};
        wb_sel_o                <= w_sel;
        wb_dat_o                <= w_st_data;
        pipeline_control_bits_o <= '0;
        register_wea_o          <= 1'b0;
        register_web_o          <= 1'b0;
      end else begin
        pipeline_control_bits_o <= pipeline_control_bits_i;
        register_wea_o          <= pipeline_control_bits_i[PCB_WA];
        register_web_o          <= pipeline_control_bits_i[PCB_WB];
        reg0_result_o           <= reg0_result_i;
        reg1_result_o           <= reg1_result_i;
        register0_write_index_o <= register0_write_index_i;
        register1_write_index_o <= register1_write_index_i;
        PC_o                    <= PC_i;
      end
    end else if (wb_ack_i) begin
      // Retire the captured instruction; stores forward reg0 for $sp updates.
      r_state                 <= ST_IDLE;
      wb_cyc_o                <= 1'b0;
      wb_stb_o                <= 1'b0;
      wb_we_o                 <= 1'b0;
      pipeline_control_bits_o <= r_h_pcb;
      register_wea_o          <= r_h_pcb[PCB_WA];
      register_web_o          <= r_h_pcb[PCB_WB];
      reg0_result_o           <= r_h_load ? w_ld_data : r_h_reg0;
      reg1_result_o           <= r_h_reg1;
      register0_write_index_o <= r_h_idx0;
      register1_write_index_o <= r_h_idx1;
      PC_o                    <= r_h_pc;
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Bench for cpu_memory: directed vector table, hand-written corner
// sequences, and a randomized instruction stream against a byte-level model.
module tb_cpu_memory;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  pipeline_control_bits_i;
  logic [1:0]  mem_size_i;
  logic [31:0] memory_address_i, mem_result_i, reg0_result_i, reg1_result_i, PC_i;
  logic [3:0]  register0_write_index_i, register1_write_index_i;
  logic        stall_o;
  logic [4:0]  pipeline_control_bits_o;
  logic        register_wea_o, register_web_o;
  logic [31:0] reg0_result_o, reg1_result_o, PC_o;
  logic [3:0]  register0_write_index_o, register1_write_index_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  cpu_memory #(.PCB_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipeline_control_bits_i(pipeline_control_bits_i), .mem_size_i(mem_size_i),
    .memory_address_i(memory_address_i), .mem_result_i(mem_result_i),
    .reg0_result_i(reg0_result_i), .reg1_result_i(reg1_result_i),
    .register0_write_index_i(register0_write_index_i),
    .register1_write_index_i(register1_write_index_i), .PC_i(PC_i),
    .stall_o(stall_o), .pipeline_control_bits_o(pipeline_control_bits_o),
    .register_wea_o(register_wea_o), .register_web_o(register_web_o),
    .reg0_result_o(reg0_result_o), .reg1_result_o(reg1_result_o),
    .register0_write_index_o(register0_write_index_o),
    .register1_write_index_o(register1_write_index_o), .PC_o(PC_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  pcb;
    logic [1:0]  size;
    logic [31:0] addr, md, r0, r1, pc;
    logic [3:0]  i0, i1;
  } ins_t;

  typedef struct {
    ins_t        ins;
    logic [31:0] ld;
    int          delay;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dato, e_reg0;
    int          e_stall;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] slv_mem [16];
  logic [7:0]  ref_mem [64];
  bit          slv_en = 1'b0;
  bit          slv_rand = 1'b0;
  int          slv_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input ins_t x);
    pipeline_control_bits_i = x.pcb;
    mem_size_i              = x.size;
    memory_address_i        = x.addr;
    mem_result_i            = x.md;
    reg0_result_i           = x.r0;
    reg1_result_i           = x.r1;
    PC_i                    = x.pc;
    register0_write_index_i = x.i0;
    register1_write_index_i = x.i1;
  endtask

  task automatic present_nop();
    ins_t z;
    z = '{pcb: 5'd0, size: 2'd0, addr: 32'd0, md: 32'd0, r0: 32'd0, r1: 32'd0,
          pc: 32'd0, i0: 4'd0, i1: 4'd0};
    present(z);
  endtask

  function automatic ins_t mki(input logic [4:0] pcb, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] md,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input logic [31:0] pc, input logic [3:0] i0,
                               input logic [3:0] i1);
    ins_t x;
    x.pcb = pcb; x.size = size; x.addr = addr; x.md = md; x.r0 = r0; x.r1 = r1;
    x.pc = pc; x.i0 = i0; x.i1 = i1;
    return x;
  endfunction

  function automatic vec_t mkv(input ins_t x, input logic [31:0] ld, input int delay,
                               input logic [31:0] e_adr, input logic [3:0] e_sel,
                               input logic [31:0] e_dato, input logic [31:0] e_reg0,
                               input int e_stall);
    vec_t v;
    v.ins = x; v.ld = ld; v.delay = delay; v.e_adr = e_adr; v.e_sel = e_sel;
    v.e_dato = e_dato; v.e_reg0 = e_reg0; v.e_stall = e_stall;
    return v;
  endfunction

  // Wishbone slave with programmable wait states, backed by slv_mem.
  initial begin
    int cnt;
    cnt = -1;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'd0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!slv_en) cnt = -1;
      else if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        cnt = -1;
      end else if (wb_cyc_o && wb_stb_o) begin
        if (cnt < 0) cnt = slv_rand ? int'($urandom_range(0, 3)) : slv_delay;
        if (cnt == 0) begin
          if (wb_we_o) begin
            for (int l = 0; l < 4; l++)
              if (wb_sel_o[l]) slv_mem[wb_adr_o[5:2]][8*l +: 8] = wb_dat_o[8*l +: 8];
            wb_dat_i = $urandom;
          end else begin
            wb_dat_i = slv_mem[wb_adr_o[5:2]];
          end
          wb_ack_i = 1'b1;
        end else cnt--;
      end else cnt = -1;
    end
  end

  // Model: memory as big-endian bytes; an access touches n bytes from offset off.
  function automatic int acc_len(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int acc_start(input logic [5:0] a, input logic [1:0] size);
    int n;
    n = acc_len(size);
    return int'(a) - (int'(a) % n);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [1:0] size);
    logic [31:0] v;
    int s;
    v = 0;
    s = acc_start(a, size);
    for (int k = 0; k < acc_len(size); k++) v = (v << 8) | 32'(ref_mem[s + k]);
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [5:0] a, input logic [1:0] size);
    logic [3:0] m;
    int off;
    m = 0;
    off = acc_start(a, size) % 4;
    for (int k = 0; k < acc_len(size); k++) m[3 - off - k] = 1'b1;
    return m;
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [1:0] size, input logic [31:0] md);
    int s, n;
    s = acc_start(a, size);
    n = acc_len(size);
    for (int k = 0; k < n; k++) ref_mem[s + k] = 8'((md >> (8 * (n - 1 - k))) & 32'hFF);
  endtask

  function automatic logic [31:0] ref_dato(input logic [1:0] size, input logic [31:0] md);
    if (size == 2'd0) return md[7:0] * 32'h01010101;
    if (size == 2'd1) return md[15:0] * 32'h00010001;
    return md;
  endfunction

  task automatic chk_emit(input string tag, input ins_t x, input logic [31:0] e0);
    chk({tag, "_pcb"}, 32'(pipeline_control_bits_o), 32'(x.pcb));
    chk({tag, "_wea"}, 32'(register_wea_o), 32'(x.pcb[0]));
    chk({tag, "_web"}, 32'(register_web_o), 32'(x.pcb[1]));
    chk({tag, "_reg0"}, reg0_result_o, e0);
    chk({tag, "_reg1"}, reg1_result_o, x.r1);
    chk({tag, "_idx"}, {24'd0, register0_write_index_o, register1_write_index_o},
        {24'd0, x.i0, x.i1});
    chk({tag, "_pc"}, PC_o, x.pc);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int st;
    string t;
    t = $sformatf("vec%0d", id);
    slv_mem[v.ins.addr[5:2]] = v.ld;
    slv_delay = v.delay;
    present(v.ins);
    step();
    present_nop();
    if (v.ins.pcb[2] || v.ins.pcb[3]) begin
      chk({t, "_cyc"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
      chk({t, "_we"}, 32'(wb_we_o), 32'(v.ins.pcb[3]));
      chk({t, "_adr"}, wb_adr_o, v.e_adr);
      chk({t, "_sel"}, 32'(wb_sel_o), 32'(v.e_sel));
      if (v.ins.pcb[3]) chk({t, "_dato"}, wb_dat_o, v.e_dato);
      chk({t, "_bubble"}, {27'd0, pipeline_control_bits_o} | 32'(register_wea_o), 32'd0);
      st = 0;
      while (stall_o && st < 20) begin
        st++;
        step();
      end
      chk({t, "_stall_cycles"}, st, v.e_stall);
      chk({t, "_cyc_drop"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    end else begin
      chk({t, "_stall"}, 32'(stall_o), 32'd0);
      chk({t, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    end
    chk_emit(t, v.ins, v.e_reg0);
    step();
    chk({t, "_drain"}, 32'(pipeline_control_bits_o), 32'd0);
  endtask

  vec_t vecs[11];
  ins_t prog[$];

  initial begin
    ins_t ld_i, alu_i, x;
    int   c, pi, em, cur_in, last_cons;
    bit   adv, prev_cyc;
    logic [31:0] e0;
    localparam int NR = 80;

    vecs[0]  = mkv(mki(5'b00001, 2'd0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'h100, 4'd3, 4'd0),
                   32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h12345678, 0);
    vecs[1]  = mkv(mki(5'b00101, 2'd0, 32'h1003, 32'h0, 32'h11111111, 32'h2, 32'h104, 4'd4, 4'd0),
                   32'hAABBCCDD, 2, 32'h1000, 4'b0001, 32'h0, 32'h000000DD, 3);
    vecs[2]  = mkv(mki(5'b01000, 2'd1, 32'h2002, 32'h0000BEEF, 32'h555, 32'h0, 32'h108, 4'd0, 4'd0),
                   32'h0, 1, 32'h2000, 4'b0011, 32'hBEEFBEEF, 32'h555, 2);
    vecs[3]  = mkv(mki(5'b00111, 2'd2, 32'h3000, 32'h0, 32'hDEAD, 32'h3004, 32'h10C, 4'd1, 4'd15),
                   32'hCAFEF00D, 0, 32'h3000, 4'b1111, 32'h0, 32'hCAFEF00D, 1);
    vecs[4]  = mkv(mki(5'b00101, 2'd0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h110, 4'd2, 4'd0),
                   32'hAABBCCDD, 0, 32'h1000, 4'b1000, 32'h0, 32'h000000AA, 1);
    vecs[5]  = mkv(mki(5'b00101, 2'd1, 32'h1001, 32'h0, 32'h0, 32'h0, 32'h114, 4'd2, 4'd0),
                   32'hAABBCCDD, 1, 32'h1000, 4'b1100, 32'h0, 32'h0000AABB, 2);
    vecs[6]  = mkv(mki(5'b00101, 2'd1, 32'h1002, 32'h0, 32'h0, 32'h0, 32'h118, 4'd2, 4'd0),
                   32'hAABBCCDD, 0, 32'h1000, 4'b0011, 32'h0, 32'h0000CCDD, 1);
    vecs[7]  = mkv(mki(5'b00101, 2'd3, 32'h1003, 32'h0, 32'h0, 32'h0, 32'h11C, 4'd2, 4'd0),
                   32'hAABBCCDD, 0, 32'h1000, 4'b1111, 32'h0, 32'hAABBCCDD, 1);
    vecs[8]  = mkv(mki(5'b01100, 2'd0, 32'h0001, 32'h123456A5, 32'h777, 32'h0, 32'h120, 4'd0, 4'd0),
                   32'h0, 0, 32'h0000, 4'b0100, 32'hA5A5A5A5, 32'h777, 1);
    vecs[9]  = mkv(mki(5'b10010, 2'd0, 32'h0, 32'h0, 32'hFFFF0000, 32'h0BADF00D, 32'h124, 4'd0, 4'd9),
                   32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF0000, 0);
    vecs[10] = mkv(mki(5'b11000, 2'd2, 32'h0042, 32'h01020304, 32'h42, 32'h0, 32'h128, 4'd0, 4'd0),
                   32'h0, 3, 32'h0040, 4'b1111, 32'h01020304, 32'h42, 4);

    // Reset state
    present_nop();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_bus", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0} | 32'(wb_sel_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dato", wb_dat_o, 32'd0);
    chk("rst_pcb", {25'd0, pipeline_control_bits_o, register_wea_o, register_web_o}, 32'd0);
    chk("rst_res", reg0_result_o | reg1_result_o | PC_o, 32'd0);

    slv_en = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Load followed by an ALU op held upstream during the stall
    slv_delay = 1;
    slv_mem[1] = 32'h5A5A1234;
    ld_i  = mki(5'b00101, 2'd2, 32'h0004, 32'h0, 32'h0, 32'h0, 32'h200, 4'd5, 4'd0);
    alu_i = mki(5'b10001, 2'd0, 32'h0, 32'h0, 32'h77, 32'h0, 32'h204, 4'd6, 4'd0);
    present(ld_i);
    step();
    present(alu_i);
    c = 0;
    while (stall_o && c < 20) begin
      c++;
      step();
    end
    chk("b2b_ld_stall", c, 2);
    chk_emit("b2b_ld", ld_i, 32'h5A5A1234);
    step();
    present_nop();
    chk_emit("b2b_alu", alu_i, 32'h77);
    step();
    chk("b2b_nodup", 32'(pipeline_control_bits_o), 32'd0);

    // Reset while a bus cycle is outstanding
    slv_en = 1'b0;
    present(ld_i);
    step();
    present_nop();
    chk("rsta_stall", 32'(stall_o), 32'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rsta_bus", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rsta_idle", 32'(stall_o), 32'd0);
    chk("rsta_we", {30'd0, register_wea_o, register_web_o}, 32'd0);
    step();
    chk("rsta_noemit", {25'd0, pipeline_control_bits_o, register_wea_o, register_web_o}, 32'd0);

    // Stray ack in IDLE
    present(alu_i);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    present_nop();
    chk("ackidle_cyc", {30'd0, wb_cyc_o, stall_o}, 32'd0);
    chk_emit("ackidle", alu_i, 32'h77);
    step();

    // Randomized instruction stream
    for (int b = 0; b < 64; b++) ref_mem[b] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      slv_mem[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
    for (int i = 0; i < NR; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      x = mki(5'b10000, 2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
              4'($urandom), 4'($urandom));
      x.pcb[1:0] = 2'($urandom);
      if (kind == 2) x.pcb[2] = 1'b1;
      if (kind == 3) begin
        x.pcb[3] = 1'b1;
        x.pcb[2] = ($urandom_range(0, 3) == 0);
      end
      prog.push_back(x);
    end
    slv_en = 1'b1;
    slv_rand = 1'b1;
    present(prog[0]);
    cur_in = 0;
    pi = 1;
    em = 0;
    last_cons = 0;
    prev_cyc = 1'b0;
    c = 0;
    while (em < NR && c < NR * 8) begin
      c++;
      adv = !stall_o;
      step();
      if (adv) last_cons = cur_in;
      if (wb_cyc_o && !prev_cyc) begin
        if (last_cons < 0) chk("rnd_spurious_cyc", 32'(wb_cyc_o), 32'd0);
        else begin
          x = prog[last_cons];
          chk("rnd_adr", wb_adr_o, {x.addr[31:2], 2'b00});
          chk("rnd_we", 32'(wb_we_o), 32'(x.pcb[3]));
          chk("rnd_sel", 32'(wb_sel_o), 32'(ref_sel(x.addr[5:0], x.size)));
          if (x.pcb[3]) chk("rnd_dato", wb_dat_o, ref_dato(x.size, x.md));
        end
      end
      prev_cyc = wb_cyc_o;
      if (pipeline_control_bits_o != 5'd0) begin
        x = prog[em];
        e0 = x.r0;
        if (x.pcb[3]) ref_store(x.addr[5:0], x.size, x.md);
        else if (x.pcb[2]) e0 = ref_load(x.addr[5:0], x.size);
        chk_emit($sformatf("rnd%0d", em), x, e0);
        em++;
      end
      if (adv) begin
        if (pi < NR) begin
          present(prog[pi]);
          cur_in = pi;
          pi++;
        end else begin
          present_nop();
          cur_in = -1;
        end
      end
    end
    chk("rnd_emitted", em, NR);
    step();
    step();
    chk("rnd_tail", 32'(pipeline_control_bits_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
